// File: rtl/ahb_arbiter.sv
// AHB bus arbiter for four masters: round-robin grant, fixed/INCR burst
// tracking, bounded hold for undefined-length INCR bursts, and registered
// address-phase / data-phase owner outputs.
// Optional feature: define AHB_ARBITER_LOCK_EN to honour HLOCK (locked
// transfers keep the grant). Without it HLOCK is ignored.
module ahb_arbiter #(
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 16
) (
  input  logic       CLK_ARBITER,
  input  logic       RESET_ARBITER,
  input  logic [3:0] HBUSREQ,
  input  logic [1:0] HTRANS,
  input  logic [2:0] HBURST,
  input  logic       HREADY,
  input  logic [3:0] HLOCK,
  output logic [3:0] HGRANT,
  output logic [1:0] HMASTER,
  output logic [1:0] HMASTER_DATA
);

  localparam int              HOLD_W   = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [1:0]      DEF_IDX  = 2'(DEFAULT_MASTER);
  localparam logic [1:0]      TR_IDLE   = 2'b00;
  localparam logic [1:0]      TR_NONSEQ = 2'b10;
  localparam logic [1:0]      TR_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_HANDOVER
  } state_t;

  state_t              r_state;
  logic [3:0]          r_hgrant;
  logic [1:0]          r_hmaster;
  logic [1:0]          r_hmaster_data;
  logic [4:0]          r_beat_cnt;
  logic [4:0]          r_burst_len;
  logic                r_incr;
  logic [HOLD_W-1:0]   r_hold_cnt;

  logic                w_accept;
  logic                w_nonseq;
  logic                w_seq;
  logic [4:0]          w_len;
  logic [4:0]          w_beat_next;
  logic [HOLD_W-1:0]   w_hold_next;
  logic                w_others;
  logic                w_arb;
  logic                w_lock_hold;
  logic [1:0]          w_winner;
  logic                w_change;

  assign HGRANT       = r_hgrant;
  assign HMASTER      = r_hmaster;
  assign HMASTER_DATA = r_hmaster_data;

  // Round-robin search starting just above the current owner; the owner
  // itself is tried last, and DEFAULT_MASTER wins when nobody requests.
  function automatic logic [1:0] f_rr_winner(input logic [1:0] cur,
                                             input logic [3:0] req);
    logic [1:0] idx;
    f_rr_winner = DEF_IDX;
    for (int k = 4; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (req[idx]) f_rr_winner = idx;
    end
  endfunction

  assign w_accept    = HREADY && HTRANS[1];
  assign w_nonseq    = w_accept && (HTRANS == TR_NONSEQ);
  assign w_seq       = w_accept && (HTRANS == TR_SEQ);
  assign w_beat_next = r_beat_cnt + 5'(w_seq);
  assign w_hold_next = (r_hold_cnt == HOLD_MAX) ? HOLD_MAX
                                                : r_hold_cnt + HOLD_W'(w_accept);
  assign w_others    = |(HBUSREQ & ~r_hgrant);
  assign w_winner    = f_rr_winner(r_hmaster, HBUSREQ);

`ifdef AHB_ARBITER_LOCK_EN
  assign w_lock_hold = HLOCK[r_hmaster];
`else
  logic w_unused_hlock;
  assign w_unused_hlock = ^HLOCK;
  assign w_lock_hold    = 1'b0;
`endif

  // Burst length decode; 0 stands for the unbounded INCR burst.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    w_len = 5'd16;
    case (HBURST)
      3'b000:         w_len = 5'd1;
      3'b001:         w_len = 5'd0;
      3'b010, 3'b011: w_len = 5'd4;
      3'b100, 3'b101: w_len = 5'd8;
      default:        w_len = 5'd16;
    endcase
  end

  // Arbitration-point detection for the current state and bus activity.
  always_comb begin
    w_arb = 1'b0;
    case (r_state)
      S_IDLE:  w_arb = (HTRANS == TR_IDLE) || (w_nonseq && (HBURST == 3'b000));
      S_BURST: w_arb = (HTRANS == TR_IDLE)
                    || (!r_incr && w_seq && (w_beat_next == r_burst_len))
                    || (r_incr && (w_hold_next == HOLD_MAX) && w_others);
      default: w_arb = 1'b0;
    endcase
  end

  assign w_change = w_arb && !w_lock_hold && (w_winner != r_hmaster);

  // Arbiter FSM with registered grant/owner outputs; frozen while HREADY=0.
  always_ff @(posedge CLK_ARBITER or negedge RESET_ARBITER) begin
    if (!RESET_ARBITER) begin
      r_state        <= S_IDLE;
      r_hgrant       <= 4'b0001 << DEF_IDX;
      r_hmaster      <= DEF_IDX;
      r_hmaster_data <= DEF_IDX;
      r_beat_cnt     <= '0;
      r_burst_len    <= '0;
      r_incr         <= 1'b0;
      r_hold_cnt     <= '0;
    end else if (HREADY) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, e.g. HMASTER_DATA takes the old HMASTER.
      r_hmaster_data <= r_hmaster;
      r_beat_cnt     <= w_beat_next;
      r_hold_cnt     <= w_change ? '0 : w_hold_next;
      if (w_arb) begin
        if (w_change) begin
          r_hgrant  <= 4'b0001 << w_winner;
          r_hmaster <= w_winner;
          r_state   <= S_HANDOVER;
        end else begin
          r_state   <= S_IDLE;
        end
      end else if (w_nonseq && (HBURST != 3'b000)) begin
        r_burst_len <= w_len;
        r_incr      <= (HBURST == 3'b001);
        r_beat_cnt  <= 5'd1;
        r_state     <= S_BURST;
      end else if (w_nonseq || (r_state == S_HANDOVER)) begin
        r_state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed self-checking bench for ahb_arbiter (default parameters).
module tb_ahb_arbiter;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic       clk;
  logic       rst_n;
  logic [3:0] hbusreq;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [3:0] hlock;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic [1:0] hmaster_data;

  int n_checks = 0;
  int n_fail   = 0;

  ahb_arbiter #(.DEFAULT_MASTER(0), .MAX_HOLD(16)) dut (
    .CLK_ARBITER  (clk),
    .RESET_ARBITER(rst_n),
    .HBUSREQ      (hbusreq),
    .HTRANS       (htrans),
    .HBURST       (hburst),
    .HREADY       (hready),
    .HLOCK        (hlock),
    .HGRANT       (hgrant),
    .HMASTER      (hmaster),
    .HMASTER_DATA (hmaster_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_owner(input string tag, input int m);
    check({tag, "_hmaster"}, 32'(hmaster), 32'(m));
    check({tag, "_hgrant"},  32'(hgrant),  32'b1 << m);
  endtask

  // Apply one cycle of bus activity, then sample just after the edge.
  task automatic step(input logic [3:0] req, input logic [1:0] tr,
                      input logic [2:0] bu, input logic rdy);
    hbusreq = req;
    htrans  = tr;
    hburst  = bu;
    hready  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    hbusreq = 4'b0000;
    htrans  = T_IDLE;
    hburst  = 3'b000;
    hready  = 1'b1;
    hlock   = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Master 1 runs an INCR4 with master 2 waiting; optional wait states on
  // the final beat, optional BUSY cycle with master 1 dropping its request.
  task automatic run_incr4(input string tag, input int waits, input bit busy_drop);
    logic [3:0] req_mid;
    req_mid = busy_drop ? 4'b0100 : 4'b0110;
    do_reset();
    step(4'b0010, T_IDLE, 3'b000, 1'b1);
    check_owner({tag, "_own1"}, 1);
    step(4'b0110, T_NONSEQ, 3'b011, 1'b1);
    check_owner({tag, "_b1"}, 1);
    step(req_mid, T_SEQ, 3'b011, 1'b1);
    check_owner({tag, "_b2"}, 1);
    if (busy_drop) begin
      step(req_mid, T_BUSY, 3'b011, 1'b1);
      check_owner({tag, "_busy"}, 1);
    end
    step(req_mid, T_SEQ, 3'b011, 1'b1);
    check_owner({tag, "_b3"}, 1);
    for (int w = 0; w < waits; w++) begin
      step(req_mid, T_SEQ, 3'b011, 1'b0);
      check_owner($sformatf("%s_wait%0d", tag, w), 1);
      check($sformatf("%s_wait%0d_data", tag, w), 32'(hmaster_data), 32'd1);
    end
    step(req_mid, T_SEQ, 3'b011, 1'b1);
    check_owner({tag, "_b4"}, 2);
    check({tag, "_b4_data"}, 32'(hmaster_data), 32'd1);
    step(4'b0100, T_IDLE, 3'b000, 1'b1);
    check_owner({tag, "_after"}, 2);
    check({tag, "_after_data"}, 32'(hmaster_data), 32'd2);
  endtask

  initial begin
    int exp_m [8] = '{1, 1, 2, 2, 3, 3, 0, 0};
    int prev_m;
    int lock_exp1, lock_exp2, lock_exp3;

    rst_n   = 1'b0;
    hbusreq = 4'b0000;
    htrans  = T_IDLE;
    hburst  = 3'b000;
    hready  = 1'b1;
    hlock   = 4'b0000;
    #12;
    check_owner("reset", 0);
    check("reset_data", 32'(hmaster_data), 32'd0);
    do_reset();

    // Round robin with everyone requesting and issuing single transfers.
    prev_m = 0;
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, T_NONSEQ, 3'b000, 1'b1);
      check_owner($sformatf("rr%0d", i), exp_m[i]);
      check($sformatf("rr%0d_data", i), 32'(hmaster_data), 32'(prev_m));
      prev_m = exp_m[i];
    end

    run_incr4("incr4", 0, 1'b0);
    run_incr4("wait3", 3, 1'b0);
    run_incr4("busy",  0, 1'b1);

    // Early termination of an INCR8 by IDLE.
    do_reset();
    step(4'b0010, T_IDLE, 3'b000, 1'b1);
    step(4'b0110, T_NONSEQ, 3'b101, 1'b1);
    step(4'b0110, T_SEQ, 3'b101, 1'b1);
    check_owner("early_mid", 1);
    step(4'b0110, T_IDLE, 3'b000, 1'b1);
    check_owner("early_end", 2);

    // Asynchronous reset in the middle of an INCR8.
    do_reset();
    step(4'b0010, T_IDLE, 3'b000, 1'b1);
    step(4'b0010, T_NONSEQ, 3'b101, 1'b1);
    step(4'b0010, T_SEQ, 3'b101, 1'b1);
    check("pre_rst_data", 32'(hmaster_data), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_owner("async_rst", 0);
    check("async_rst_data", 32'(hmaster_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0100, T_NONSEQ, 3'b000, 1'b1);
    check_owner("post_rst_arb", 2);

    // INCR hold limit: master 3 bursts while master 0 waits.
    do_reset();
    step(4'b1000, T_IDLE, 3'b000, 1'b1);
    check_owner("hold_own3", 3);
    for (int b = 1; b <= 16; b++) begin
      step(4'b1001, (b == 1) ? T_NONSEQ : T_SEQ, 3'b001, 1'b1);
      check_owner($sformatf("hold_beat%0d", b), (b < 16) ? 3 : 0);
    end

    // INCR with nobody else requesting runs past the limit, then yields.
    do_reset();
    step(4'b1000, T_IDLE, 3'b000, 1'b1);
    for (int b = 1; b <= 20; b++)
      step(4'b1000, (b == 1) ? T_NONSEQ : T_SEQ, 3'b001, 1'b1);
    check_owner("sat_alone", 3);
    step(4'b1001, T_SEQ, 3'b001, 1'b1);
    check_owner("sat_yield", 0);

    // Locked master 2 over two INCR4s.
`ifdef AHB_ARBITER_LOCK_EN
    lock_exp1 = 2; lock_exp2 = 2; lock_exp3 = 3;
`else
    lock_exp1 = 3; lock_exp2 = 0; lock_exp3 = 0;
`endif
    do_reset();
    step(4'b0100, T_IDLE, 3'b000, 1'b1);
    check_owner("lock_own2", 2);
    hlock = 4'b0100;
    step(4'b1111, T_NONSEQ, 3'b011, 1'b1);
    repeat (3) step(4'b1111, T_SEQ, 3'b011, 1'b1);
    check_owner("lock_burst1", lock_exp1);
    step(4'b1111, T_NONSEQ, 3'b011, 1'b1);
    repeat (3) step(4'b1111, T_SEQ, 3'b011, 1'b1);
    check_owner("lock_burst2", lock_exp2);
    hlock = 4'b0000;
    step(4'b1111, T_IDLE, 3'b000, 1'b1);
    check_owner("lock_release", lock_exp3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 The block SHALL have parameter DEFAULT_MASTER, default 0, giving the master index granted when no master requests.
REQ-002 The block SHALL have parameter MAX_HOLD, default 16, giving the accepted-beat limit for an undefined-length INCR burst while another master requests.
REQ-003 The block SHALL have port CLK_ARBITER  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port RESET_ARBITER  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port HBUSREQ  input  4  per-master bus request, bit i for master i.
REQ-006 The block SHALL have port HTRANS  input  2  transfer type of the current address-phase owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-007 The block SHALL have port HBURST  input  3  burst type of the current owner, sampled on NONSEQ.
REQ-008 The block SHALL have port HREADY  input  1  slave ready; a beat is accepted when HREADY=1 and HTRANS is NONSEQ or SEQ.
REQ-009 The block SHALL have port HLOCK  input  4  per-master lock request; it is used only when the REQ-030 macro is defined.
REQ-010 The block SHALL have port HGRANT  output  4  one-hot grant, registered.
REQ-011 The block SHALL have port HMASTER  output  2  address-phase owner index, registered.
REQ-012 The block SHALL have port HMASTER_DATA  output  2  data-phase owner index, registered.

Function
REQ-013 The FSM SHALL have exactly three states: S_IDLE (owner not bursting), S_BURST (fixed or INCR burst in progress) and S_HANDOVER (first cycle after a grant change).
REQ-014 HGRANT and HMASTER SHALL change only on an edge where HREADY=1 at an arbitration point, and SHALL always be consistent: HGRANT = 1<<HMASTER.
REQ-015 Arbitration points SHALL be:
- S_IDLE with HTRANS=IDLE;
- S_IDLE with an accepted NONSEQ of HBURST=000;
- S_BURST with acceptance of the final beat;
- S_BURST with HTRANS=IDLE (early termination);
- S_BURST with an INCR burst whose hold counter has reached MAX_HOLD while any other HBUSREQ bit is set.
REQ-016 Winner selection SHALL be round-robin, searching indices (HMASTER+1) mod 4 upward; the first set HBUSREQ bit wins; if none is set, DEFAULT_MASTER wins.
REQ-017 If the winner equals HMASTER, the grant SHALL be unchanged and the next state is S_IDLE; otherwise the grant SHALL update and the next state is S_HANDOVER.
REQ-018 S_HANDOVER SHALL last exactly one cycle with no arbitration, and SHALL then evaluate as S_IDLE on the following cycle.
REQ-019 An accepted NONSEQ in S_IDLE or S_HANDOVER with HBURST≠000 SHALL load the burst length and enter S_BURST with beat count 1.
REQ-020 Burst lengths SHALL be:
- 000 → 1;
- 010/011 → 4;
- 100/101 → 8;
- 110/111 → 16;
- 001 (INCR) → unbounded.
REQ-021 The 5-bit beat counter SHALL increment on each accepted SEQ, and BUSY SHALL not increment it; the final beat is the accepted SEQ bringing the count to the burst length.
REQ-022 The INCR hold counter SHALL count accepted beats, saturate at MAX_HOLD, and clear on every grant change.
REQ-023 With HREADY=0 all state, counters and outputs SHALL hold.
REQ-024 HMASTER_DATA SHALL load HMASTER on every edge with HREADY=1.
REQ-025 HBUSREQ deassertion by the owner mid-burst SHALL not end the burst.

Reset
REQ-026 On RESET_ARBITER low, asynchronously, HGRANT SHALL become 1<<DEFAULT_MASTER and HMASTER and HMASTER_DATA SHALL become DEFAULT_MASTER.
REQ-027 On RESET_ARBITER low, the state SHALL become S_IDLE and both counters SHALL become 0, including when reset arrives mid-burst.
REQ-028 After reset release, the first arbitration SHALL occur on the first rising edge meeting REQ-015.

Configuration
REQ-029 HLOCK SHALL be ignored and synthesise no logic when AHB_ARBITER_LOCK_EN is undefined.
REQ-030 When AHB_ARBITER_LOCK_EN is defined, an arbitration point with HLOCK[HMASTER]=1 SHALL keep the current grant, including past MAX_HOLD; the lock SHALL release at the first arbitration point with HLOCK[HMASTER]=0.

Verification
REQ-031 Reset scenario: RESET_ARBITER low mid-INCR8 with DEFAULT_MASTER=0 → HGRANT=0001, HMASTER=0, HMASTER_DATA=0 immediately.
REQ-032 Round-robin scenario: HBUSREQ=1111, every owner issues single NONSEQ, HREADY=1 → HMASTER sequence 0,1,2,3,0, with S_HANDOVER between each.
REQ-033 INCR4 scenario: master 1 issues INCR4 while HBUSREQ[2]=1 → HGRANT=0010 for 4 accepted beats, then 0100 on the edge after beat 4.
REQ-034 Wait-state scenario: HREADY=0 for 3 cycles on the final INCR4 beat → grant unchanged until the edge where HREADY returns to 1; HMASTER_DATA lags HMASTER by one ready edge.
REQ-035 INCR hold scenario: master 3 issues INCR with HBUSREQ[0]=1 and MAX_HOLD=16 → grant moves to master 0 after the 16th accepted beat.
REQ-036 Lock scenario: with AHB_ARBITER_LOCK_EN, HLOCK[2]=1 over two INCR4s and HBUSREQ=1111 → HMASTER stays 2 until HLOCK[2]=0; without the macro → grant changes after the first INCR4.
